// File: rtl/sisc_ir_sequencer.sv
// -----------------------------------------------------------------------------
// sisc_ir_sequencer
//   Instruction sequencer for the SISC core. It holds a loadable program store,
//   owns the PC, and drives ir into the core through a multi-cycle
//   FETCH -> DECODE -> EXECUTE -> MEM -> WB sequence. It also detects halt
//   instructions, applies branch redirects, honours stalls, and counts retired
//   instructions.
//
// Ports
//   clk        in   rising-edge system clock
//   rst_f      in   asynchronous active-low reset
//   load_en    in   program-store write strobe (honoured in IDLE/HALT only)
//   load_addr  in   program-store write address (>= DEPTH ignored)
//   load_data  in   program-store write data
//   start      in   leave IDLE/HALT and fetch from start_pc
//   start_pc   in   first PC after start (reduced modulo DEPTH)
//   stall      in   hold in EXECUTE or MEM while high
//   br_taken   in   sampled in WB: redirect PC to br_addr
//   br_addr    in   branch target (reduced modulo DEPTH)
//   ir         out  instruction register to the core
//   ir_valid   out  high in DECODE, EXECUTE, MEM and WB
//   pc         out  address of the next instruction to fetch
//   phase      out  IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4 WB=5 HALT=6
//   halted     out  high in HALT
//   retired    out  retired-instruction count, saturating at all-ones
// -----------------------------------------------------------------------------
module sisc_ir_sequencer #(
    parameter int         DATA_W = 32,
    parameter int         ADDR_W = 6,
    parameter int         DEPTH  = 64,
    parameter int         CNT_W  = 16,
    parameter logic [3:0] HLT_OP = 4'hF
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        phase,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FETCH  = 3'd1,
        PH_DECODE = 3'd2,
        PH_EXEC   = 3'd3,
        PH_MEM    = 3'd4,
        PH_WB     = 3'd5,
        PH_HALT   = 3'd6
    } phase_e;

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

    phase_e              phase_q, phase_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                store_we;

    logic [DATA_W-1:0]   store [DEPTH];

    // Externally supplied addresses may exceed the store; fold them back in.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] r;
        r = {1'b0, a} % DEPTH_X;
        return r[ADDR_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        phase_d   = phase_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        store_we  = 1'b0;

        unique case (phase_q)
            PH_IDLE, PH_HALT: begin
                store_we = load_en && ({1'b0, load_addr} < DEPTH_X);
                if (start) begin
                    pc_d    = wrap_addr(start_pc);
                    phase_d = PH_FETCH;
                end
            end
            PH_FETCH: begin
                ir_d    = store[pc_q];
                pc_d    = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
                phase_d = PH_DECODE;
            end
            PH_DECODE: begin
                // A halt instruction retires here; it never reaches WB.
                if (ir_q[DATA_W-1 -: 4] == HLT_OP) begin
                    retired_d = sat_inc(retired_q);
                    phase_d   = PH_HALT;
                end else begin
                    phase_d = PH_EXEC;
                end
            end
            PH_EXEC: if (!stall) phase_d = PH_MEM;
            PH_MEM:  if (!stall) phase_d = PH_WB;
            PH_WB: begin
                retired_d = sat_inc(retired_q);
                if (br_taken) pc_d = wrap_addr(br_addr);
                phase_d = PH_FETCH;
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            phase_q   <= PH_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            phase_q   <= phase_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // NOTE: the program store has no reset; contents survive rst_f so a loaded
    // program can be rerun, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (store_we) store[load_addr] <= load_data;
    end

    assign ir       = ir_q;
    assign pc       = pc_q;
    assign phase    = phase_q;
    assign retired  = retired_q;
    assign halted   = (phase_q == PH_HALT);
    assign ir_valid = (phase_q == PH_DECODE) || (phase_q == PH_EXEC) ||
                      (phase_q == PH_MEM)    || (phase_q == PH_WB);

endmodule

// File: tb/tb_sisc_ir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sisc_ir_sequencer
//   Directed and randomized bench for sisc_ir_sequencer. The reference model is
//   an array image of the program store, an integer PC and an integer retire
//   count, advanced one instruction at a time. A second instance with CNT_W=2
//   shares all stimulus and exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_sisc_ir_sequencer;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int DP = 64;

    logic          clk;
    logic          rst_f;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          start;
    logic [AW-1:0] start_pc;
    logic          stall;
    logic          br_taken;
    logic [AW-1:0] br_addr;

    logic [DW-1:0] ir,       ir_s;
    logic          ir_valid, ir_valid_s;
    logic [AW-1:0] pc,       pc_s;
    logic [2:0]    phase,    phase_s;
    logic          halted,   halted_s;
    logic [15:0]   retired;
    logic [1:0]    retired_s;

    sisc_ir_sequencer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .CNT_W(16)) u_dut (
        .clk(clk), .rst_f(rst_f), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .start_pc(start_pc), .stall(stall),
        .br_taken(br_taken), .br_addr(br_addr), .ir(ir), .ir_valid(ir_valid),
        .pc(pc), .phase(phase), .halted(halted), .retired(retired)
    );

    sisc_ir_sequencer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .CNT_W(2)) u_sat (
        .clk(clk), .rst_f(rst_f), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .start_pc(start_pc), .stall(stall),
        .br_taken(br_taken), .br_addr(br_addr), .ir(ir_s), .ir_valid(ir_valid_s),
        .pc(pc_s), .phase(phase_s), .halted(halted_s), .retired(retired_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model
    logic [DW-1:0] mem_m [DP];
    int            pc_m;
    int            ret_m;
    logic [DW-1:0] prog1 [12];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] non_halt_word();
        logic [DW-1:0] w;
        w = $urandom;
        if (w[31:28] == 4'hF) w[31:28] = 4'h7;
        return w;
    endfunction

    // Checks the visible state of both instances against one expected phase.
    task automatic check_state(input string tag, input int ph, input logic [DW-1:0] w,
                               input int pcx);
        logic vld;
        vld = (ph >= 2) && (ph <= 5);
        check({tag, ".phase"},    32'(phase),      32'(ph));
        check({tag, ".ir"},       ir,              w);
        check({tag, ".pc"},       32'(pc),         32'(pcx));
        check({tag, ".ir_valid"}, 32'(ir_valid),   32'(vld));
        check({tag, ".halted"},   32'(halted),     32'(ph == 6));
        check({tag, ".s_phase"},  32'(phase_s),    32'(ph));
        check({tag, ".s_ir"},     ir_s,            w);
        check({tag, ".s_pc"},     32'(pc_s),       32'(pcx));
        check({tag, ".s_vld"},    32'(ir_valid_s), 32'(vld));
        check({tag, ".s_halt"},   32'(halted_s),   32'(ph == 6));
    endtask

    task automatic check_ret(input string tag);
        check({tag, ".retired"},   32'(retired),   (ret_m > 65535) ? 32'd65535 : 32'(ret_m));
        check({tag, ".retired_s"}, 32'(retired_s), (ret_m > 3) ? 32'd3 : 32'(ret_m));
    endtask

    task automatic clear_inputs();
        load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; start_pc = '0; stall = 1'b0; br_taken = 1'b0; br_addr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_f = 1'b0;
        tick();
        tick();
        pc_m  = 0;
        ret_m = 0;
        check_state("reset", 0, '0, 0);
        check_ret("reset");
        rst_f = 1'b1;
        tick();
    endtask

    task automatic load_word(input int addr, input logic [DW-1:0] data);
        load_en = 1'b1; load_addr = AW'(addr); load_data = data;
        tick();
        load_en = 1'b0;
        if (addr < DP) mem_m[addr] = data;
    endtask

    task automatic start_at(input int pc0, input logic [DW-1:0] ir_now);
        start = 1'b1; start_pc = AW'(pc0);
        tick();
        start = 1'b0;
        pc_m = pc0 % DP;
        check_state("start", 1, ir_now, pc_m);
    endtask

    // Runs one instruction from FETCH. Returns h=1 if it was a halt.
    // If abort_mem is set, rst_f is pulled low mid-way through MEM.
    task automatic step(input int se, input int sm, input bit br, input logic [AW-1:0] ba,
                        input bit poke, input bit abort_mem, output bit h);
        logic [DW-1:0] w;
        int            c0;
        h  = 1'b0;
        c0 = cyc;
        w  = mem_m[pc_m];
        pc_m = (pc_m + 1) % DP;
        stall = 1'($urandom); br_taken = 1'($urandom); br_addr = AW'($urandom);
        tick();
        check_state("decode", 2, w, pc_m);
        stall = 1'($urandom);
        if (w[31:28] == 4'hF) begin
            tick();
            ret_m++;
            check_state("halt", 6, w, pc_m);
            check_ret("halt");
            stall = 1'b0; br_taken = 1'b0;
            h = 1'b1;
            return;
        end
        tick();
        check_state("exec", 3, w, pc_m);
        for (int i = 0; i < se; i++) begin
            stall = 1'b1;
            if (poke) begin
                load_en = 1'b1; load_addr = AW'(pc_m); load_data = ~mem_m[pc_m];
            end
            tick();
            load_en = 1'b0;
            check_state("exec_stall", 3, w, pc_m);
        end
        stall = 1'b0;
        tick();
        check_state("mem", 4, w, pc_m);
        if (abort_mem) begin
            #3 rst_f = 1'b0;
            #1;
            ret_m = 0;
            pc_m  = 0;
            check_state("async_rst", 0, '0, 0);
            check_ret("async_rst");
            tick();
            rst_f = 1'b1;
            clear_inputs();
            tick();
            return;
        end
        for (int i = 0; i < sm; i++) begin
            stall = 1'b1;
            tick();
            check_state("mem_stall", 4, w, pc_m);
        end
        stall = 1'b0;
        tick();
        check_state("wb", 5, w, pc_m);
        stall = 1'($urandom); br_taken = br; br_addr = ba;
        tick();
        ret_m++;
        if (br) pc_m = int'(ba) % DP;
        check_state("refetch", 1, w, pc_m);
        check_ret("wb");
        check("instr_cycles", 32'(cyc - c0), 32'(5 + se + sm));
        stall = 1'b0; br_taken = 1'b0;
    endtask

    task automatic run_to_halt(input int limit, output int n);
        bit h;
        n = 0;
        h = 1'b0;
        while (!h && n < limit) begin
            step(0, 0, 1'b0, '0, 1'b0, 1'b0, h);
            n++;
        end
        check("run_halted", 32'(h), 32'd1);
    endtask

    initial begin
        bit h;
        int n;
        int c0;
        logic [DW-1:0] w;

        rst_f = 1'b0;
        clear_inputs();
        do_reset();

        // Fill the whole store so any fetch address has a known image.
        for (int a = 0; a < DP; a++) load_word(a, non_halt_word());

        // Arithmetic program ending in a halt at address 11.
        prog1[0]  = 32'h88100001;
        for (int i = 1; i < 10; i++) prog1[i] = non_halt_word();
        prog1[10] = 32'h80324006;
        prog1[11] = 32'hF0000000;
        for (int i = 0; i < 12; i++) load_word(i, prog1[i]);

        start_at(0, '0);
        c0 = cyc;
        run_to_halt(20, n);
        check("t1_count", 32'(n), 32'd12);
        check("t1_halt_cycle", 32'(cyc - c0), 32'd57);
        check("t1_retired", 32'(retired), 32'd12);
        check("t1_retired_sat", 32'(retired_s), 32'd3);

        // Three-cycle stall in EXECUTE of the first instruction, with an
        // ignored store write to the next fetch address during the stall.
        start_at(0, 32'hF0000000);
        step(3, 0, 1'b0, '0, 1'b1, 1'b0, h);
        step(0, 2, 1'b0, '0, 1'b0, 1'b0, h);
        run_to_halt(20, n);

        // PC wrap from the last store word.
        do_reset();
        load_word(63, 32'h00000000);
        load_word(0, 32'hF0000000);
        start_at(63, '0);
        step(0, 0, 1'b0, '0, 1'b0, 1'b0, h);
        step(0, 0, 1'b0, '0, 1'b0, 1'b0, h);
        check("t3_halted", 32'(h), 32'd1);
        check("t3_retired", 32'(retired), 32'd2);

        // Branch from address 2 to address 5; 3 and 4 must never be fetched.
        do_reset();
        for (int a = 0; a < 5; a++) load_word(a, non_halt_word());
        load_word(5, 32'hF0000005);
        start_at(0, '0);
        step(0, 0, 1'b0, '0, 1'b0, 1'b0, h);
        step(0, 0, 1'b0, '0, 1'b0, 1'b0, h);
        step(0, 0, 1'b1, 6'd5, 1'b0, 1'b0, h);
        step(0, 0, 1'b0, '0, 1'b0, 1'b0, h);
        check("t4_halt_ir", ir, 32'hF0000005);

        // Reset during MEM, then rerun the arithmetic program from the store.
        do_reset();
        for (int i = 0; i < 12; i++) load_word(i, prog1[i]);
        start_at(0, '0);
        step(0, 0, 1'b0, '0, 1'b0, 1'b0, h);
        step(0, 0, 1'b0, '0, 1'b0, 1'b1, h);
        start_at(0, '0);
        run_to_halt(20, n);
        check("t5_count", 32'(n), 32'd12);

        // Randomized runs: load+start in the same cycle, random stalls,
        // branches and ignored writes, with a few halts scattered in the store.
        do_reset();
        for (int k = 0; k < 6; k++) load_word($urandom_range(0, DP - 1), 32'hF0000000);
        for (int r = 0; r < 6; r++) begin
            int sp;
            sp = $urandom_range(0, DP - 1);
            w  = non_halt_word();
            load_en = 1'b1; load_addr = AW'(sp); load_data = w;
            start = 1'b1; start_pc = AW'(sp);
            tick();
            load_en = 1'b0; start = 1'b0;
            mem_m[sp] = w;
            pc_m = sp;
            check("rand_start_phase", 32'(phase), 32'd1);
            check("rand_start_pc", 32'(pc), 32'(sp));
            h = 1'b0;
            for (int k = 0; k < 25 && !h; k++) begin
                step($urandom_range(0, 2), $urandom_range(0, 2),
                     ($urandom_range(0, 3) == 0), AW'($urandom), ($urandom_range(0, 4) == 0),
                     1'b0, h);
            end
            if (!h) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
